// File: rtl/cpu_defs.sv
// Shared CPU definitions: opcode map, phase encoding, strobe bundle, ALU-op helper.
// Used by the phase controller and reused by the IR/ALU for the opcode constants.
package cpu_defs;

    localparam int unsigned OPCODE_W = 3;
    localparam int unsigned PHASE_W  = 3;

    localparam logic [OPCODE_W-1:0] OP_HLT = 3'b000;
    localparam logic [OPCODE_W-1:0] OP_SKZ = 3'b001;
    localparam logic [OPCODE_W-1:0] OP_ADD = 3'b010;
    localparam logic [OPCODE_W-1:0] OP_AND = 3'b011;
    localparam logic [OPCODE_W-1:0] OP_XOR = 3'b100;
    localparam logic [OPCODE_W-1:0] OP_LDA = 3'b101;
    localparam logic [OPCODE_W-1:0] OP_STO = 3'b110;
    localparam logic [OPCODE_W-1:0] OP_JMP = 3'b111;

    // Instruction-cycle phases, in execution order.
    typedef enum logic [PHASE_W-1:0] {
        PH_INST_ADDR  = 3'd0,
        PH_INST_FETCH = 3'd1,
        PH_INST_LOAD  = 3'd2,
        PH_IDLE       = 3'd3,
        PH_OP_ADDR    = 3'd4,
        PH_OP_FETCH   = 3'd5,
        PH_ALU_OP     = 3'd6,
        PH_STORE      = 3'd7
    } phase_e;

    // Datapath control strobes driven by the controller.
    typedef struct packed {
        logic sel;
        logic rd;
        logic ld_ir;
        logic inc_pc;
        logic halt;
        logic ld_pc;
        logic data_e;
        logic ld_ac;
        logic wr;
    } strobe_t;

    // Opcodes whose result comes back through the ALU into the accumulator.
    function automatic logic is_aluop(input logic [OPCODE_W-1:0] op);
        return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
    endfunction

endpackage

// File: rtl/cpu_phase_decode.sv
// Purely combinational map of (phase, opcode, zero, halted) to the strobe vector.
// Ports:
//   i_phase  - current phase register
//   i_opcode - opcode from the instruction register
//   i_zero   - accumulator zero flag (only meaningful in the ALU_OP phase)
//   i_halted - sticky halted flag; forces every strobe except halt low
//   o_strobe - decoded strobe bundle
module cpu_phase_decode
    import cpu_defs::*;
(
    input  logic [PHASE_W-1:0]  i_phase,
    input  logic [OPCODE_W-1:0] i_opcode,
    input  logic                i_zero,
    input  logic                i_halted,
    output strobe_t             o_strobe
);

    logic w_aluop;
    logic w_is_hlt;
    logic w_is_skz;
    logic w_is_sto;
    logic w_is_jmp;

    assign w_aluop  = is_aluop(i_opcode);
    assign w_is_hlt = (i_opcode == OP_HLT);
    assign w_is_skz = (i_opcode == OP_SKZ);
    assign w_is_sto = (i_opcode == OP_STO);
    assign w_is_jmp = (i_opcode == OP_JMP);

    // Phase/opcode decode; anything not set for a phase stays 0.
    always_comb begin
        o_strobe = '0;
        if (i_halted) begin
            o_strobe.halt = 1'b1;
        end else begin
            case (phase_e'(i_phase))
                PH_INST_ADDR: begin
                    o_strobe.sel = 1'b1;
                end
                PH_INST_FETCH: begin
                    o_strobe.sel = 1'b1;
                    o_strobe.rd  = 1'b1;
                end
                PH_INST_LOAD, PH_IDLE: begin
                    o_strobe.sel   = 1'b1;
                    o_strobe.rd    = 1'b1;
                    o_strobe.ld_ir = 1'b1;
                end
                PH_OP_ADDR: begin
                    o_strobe.inc_pc = 1'b1;
                    o_strobe.halt   = w_is_hlt;
                end
                PH_OP_FETCH: begin
                    o_strobe.rd = w_aluop;
                end
                PH_ALU_OP: begin
                    o_strobe.rd     = w_aluop;
                    // SKZ skips the next instruction by bumping the PC a second time.
                    o_strobe.inc_pc = w_is_skz & i_zero;
                    o_strobe.ld_pc  = w_is_jmp;
                    o_strobe.data_e = w_is_sto;
                end
                PH_STORE: begin
                    o_strobe.rd     = w_aluop;
                    o_strobe.ld_ac  = w_aluop;
                    o_strobe.ld_pc  = w_is_jmp;
                    o_strobe.data_e = w_is_sto;
                    o_strobe.wr     = w_is_sto;
                end
                default: begin
                    o_strobe = '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/cpu_phase_controller.sv
// Central 8-phase instruction sequencer for the 8-bit RISC CPU.
// Holds the phase counter and sticky halted flag; strobes are decoded
// combinationally so that during reset they already show the phase-0 decode.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   opcode      - opcode from the instruction register (stable from phase 3)
//   zero        - accumulator zero flag
//   phase       - current phase (observability)
//   sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr - datapath strobes
module cpu_phase_controller
    import cpu_defs::*;
#(
    parameter int unsigned NUM_PHASES = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] opcode,
    input  logic       zero,
    output logic [2:0] phase,
    output logic       sel,
    output logic       rd,
    output logic       ld_ir,
    output logic       inc_pc,
    output logic       halt,
    output logic       ld_pc,
    output logic       data_e,
    output logic       ld_ac,
    output logic       wr
);

    phase_e  r_phase;
    phase_e  w_phase_nxt;
    logic    r_halted;
    logic    w_halted_nxt;
    strobe_t w_strobe;

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase  <= PH_INST_ADDR;
            r_halted <= 1'b0;
        end else begin
            r_phase  <= w_phase_nxt;
            r_halted <= w_halted_nxt;
        end
    end

    // Next state: free-running phase, frozen at OP_ADDR once HLT is seen.
    always_comb begin
        w_phase_nxt  = r_phase;
        w_halted_nxt = r_halted;
        if (!r_halted) begin
            if ((r_phase == PH_OP_ADDR) && (opcode == OP_HLT)) begin
                w_halted_nxt = 1'b1;
            end else begin
                w_phase_nxt = phase_e'(r_phase + 3'd1);
            end
        end
    end

    cpu_phase_decode u_decode (
        .i_phase  (r_phase),
        .i_opcode (opcode),
        .i_zero   (zero),
        .i_halted (r_halted),
        .o_strobe (w_strobe)
    );

    assign phase  = r_phase;
    assign sel    = w_strobe.sel;
    assign rd     = w_strobe.rd;
    assign ld_ir  = w_strobe.ld_ir;
    assign inc_pc = w_strobe.inc_pc;
    assign halt   = w_strobe.halt;
    assign ld_pc  = w_strobe.ld_pc;
    assign data_e = w_strobe.data_e;
    assign ld_ac  = w_strobe.ld_ac;
    assign wr     = w_strobe.wr;

    // Structural invariants of the strobe set.
    a_rd_wr_excl: assert property (@(posedge clk) disable iff (!rst_n) !(rd && wr));
    a_pc_excl:    assert property (@(posedge clk) disable iff (!rst_n) !(ld_pc && inc_pc));
    a_wr_phase:   assert property (@(posedge clk) disable iff (!rst_n) wr |-> (r_phase == PH_STORE));
    a_phase_rng:  assert property (@(posedge clk) disable iff (!rst_n) (32'(r_phase) < NUM_PHASES));

endmodule

// File: tb/tb_cpu_phase_controller.sv
// Directed bench for cpu_phase_controller: walks full instruction cycles for
// several opcodes against hand-written strobe tables, then halt and async reset.
module tb_cpu_phase_controller;

    logic       clk;
    logic       rst_n;
    logic [2:0] opcode;
    logic       zero;
    logic [2:0] phase;
    logic       sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr;

    int unsigned total;
    int unsigned bad;

    // Strobe vector order: {sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr}
    logic [8:0] vec;
    assign vec = {sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr};

    cpu_phase_controller #(.NUM_PHASES(8)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .opcode (opcode),
        .zero   (zero),
        .phase  (phase),
        .sel    (sel),
        .rd     (rd),
        .ld_ir  (ld_ir),
        .inc_pc (inc_pc),
        .halt   (halt),
        .ld_pc  (ld_pc),
        .data_e (data_e),
        .ld_ac  (ld_ac),
        .wr     (wr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Exclusivity checks every active cycle, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("rd_wr_excl", 32'(rd & wr), 32'd0);
            chk("pc_excl", 32'(ld_pc & inc_pc), 32'd0);
            if (wr) chk("wr_phase", 32'(phase), 32'd7);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full instruction from phase 0; phases 0-4 are common to all non-HLT opcodes.
    task automatic run_instr(input string tag, input logic [2:0] op,
                             input logic [8:0] e5, input logic [8:0] e6, input logic [8:0] e7,
                             input logic z5, input logic z6, input logic z7);
        logic [8:0] exp_v [8];
        exp_v[0] = 9'b100000000;
        exp_v[1] = 9'b110000000;
        exp_v[2] = 9'b111000000;
        exp_v[3] = 9'b111000000;
        exp_v[4] = 9'b000100000;
        exp_v[5] = e5;
        exp_v[6] = e6;
        exp_v[7] = e7;
        opcode = op;
        for (int p = 0; p < 8; p++) begin
            zero = (p == 5) ? z5 : (p == 6) ? z6 : (p == 7) ? z7 : 1'b0;
            #1;
            chk($sformatf("%s_phase%0d", tag, p), 32'(phase), 32'(p));
            chk($sformatf("%s_vec%0d", tag, p), 32'(vec), 32'(exp_v[p]));
            step();
        end
        zero = 1'b0;
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        rst_n  = 1'b0;
        opcode = 3'b101;
        zero   = 1'b0;

        // Reset held for 3 clocks: phase-0 decode visible throughout.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_phase", 32'(phase), 32'd0);
        chk("rst_vec", 32'(vec), 32'h100);
        rst_n = 1'b1;
        #1;
        chk("rel_phase", 32'(phase), 32'd0);
        step();
        chk("first_edge_phase", 32'(phase), 32'd1);
        // Realign to phase 0.
        repeat (7) step();

        run_instr("lda", 3'b101, 9'b010000000, 9'b010000000, 9'b010000010, 1'b0, 1'b0, 1'b0);
        run_instr("sto", 3'b110, 9'b000000000, 9'b000000100, 9'b000000101, 1'b0, 1'b0, 1'b0);
        run_instr("jmp", 3'b111, 9'b000000000, 9'b000001000, 9'b000001000, 1'b0, 1'b0, 1'b0);
        run_instr("skz1", 3'b001, 9'b000000000, 9'b000100000, 9'b000000000, 1'b0, 1'b1, 1'b0);
        run_instr("skz0", 3'b001, 9'b000000000, 9'b000000000, 9'b000000000, 1'b1, 1'b0, 1'b1);
        run_instr("add", 3'b010, 9'b010000000, 9'b010000000, 9'b010000010, 1'b0, 1'b0, 1'b0);
        run_instr("xor", 3'b100, 9'b010000000, 9'b010000000, 9'b010000010, 1'b1, 1'b1, 1'b1);

        // Halt: HLT decoded in phase 4, then frozen there.
        opcode = 3'b000;
        repeat (4) step();
        chk("hlt_p4_phase", 32'(phase), 32'd4);
        chk("hlt_p4_halt", 32'(halt), 32'd1);
        for (int i = 0; i < 20; i++) begin
            step();
            if (i == 5) opcode = 3'b010;
            if (i == 12) zero = 1'b1;
            #1;
            chk($sformatf("halted_phase%0d", i), 32'(phase), 32'd4);
            chk($sformatf("halted_vec%0d", i), 32'(vec), 32'h010);
        end
        zero = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("hlt_rst_phase", 32'(phase), 32'd0);
        chk("hlt_rst_halt", 32'(halt), 32'd0);
        chk("hlt_rst_vec", 32'(vec), 32'h100);
        step();
        rst_n  = 1'b1;
        opcode = 3'b110;
        step();
        chk("post_hlt_phase", 32'(phase), 32'd1);

        // Async reset in the middle of a store's phase 7.
        repeat (6) step();
        chk("sto_p7_phase", 32'(phase), 32'd7);
        chk("sto_p7_wr", 32'(wr), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_wr", 32'(wr), 32'd0);
        chk("async_phase", 32'(phase), 32'd0);
        chk("async_vec", 32'(vec), 32'h100);
        step();
        rst_n = 1'b1;
        step();
        chk("async_rel_phase", 32'(phase), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cpu_phase_controller.md
Name: cpu_phase_controller

Overview:
- Central sequencer for the 8-bit RISC CPU. Runs an 8-phase instruction cycle.
- Decodes the 3-bit opcode held in the instruction register and the accumulator zero flag.
- Produces all load/enable/select strobes for the PC, IR, accumulator, memory and data bus.
- Sits between the instruction register and the datapath; one instruction completes every 8 clocks.

Parameters:
- NUM_PHASES, 8, number of phases per instruction cycle; fixed at 8, kept as a parameter for assertions only.

Ports:
- clk     input   1  system clock; all state changes on the rising edge
- rst_n   input   1  asynchronous, active-low reset
- opcode  input   3  current opcode from the instruction register
- zero    input   1  accumulator == 0 flag from the ALU/accumulator
- phase   output  3  current phase register value (debug/observability)
- sel     output  1  1 = address mux selects PC, 0 = selects IR address field
- rd      output  1  memory read enable
- ld_ir   output  1  load instruction register
- inc_pc  output  1  increment program counter
- halt    output  1  CPU halted (sticky)
- ld_pc   output  1  load PC from IR address field (jump)
- data_e  output  1  drive accumulator onto data bus
- ld_ac   output  1  load accumulator from ALU result
- wr      output  1  memory write strobe

Behaviour:
- Reset: phase=0 (INST_ADDR), halted flag=0, asynchronously on rst_n low.
  - During reset, outputs equal the phase-0 decode: sel=1, all others 0.
  - Release takes effect on the next rising edge.
- Phases advance 0→1→…→7→0, one per clock, with 3-bit wrap-around.
- Opcode map, shared with the IR: 000 HLT, 001 SKZ, 010 ADD, 011 AND, 100 XOR, 101 LDA, 110 STO, 111 JMP.
- ALUOP = ADD | AND | XOR | LDA.
- Outputs are decoded combinationally from the phase register, opcode and zero. No glitch-sensitive loads: all consumers sample on clk.
- Phase decode:
  - 0 INST_ADDR: sel=1
  - 1 INST_FETCH: sel=1, rd=1
  - 2 INST_LOAD: sel=1, rd=1, ld_ir=1
  - 3 IDLE: sel=1, rd=1, ld_ir=1
  - 4 OP_ADDR: inc_pc=1; halt=1 if opcode==HLT
  - 5 OP_FETCH: rd=ALUOP
  - 6 ALU_OP: rd=ALUOP; inc_pc=(SKZ & zero); ld_pc=JMP; data_e=STO
  - 7 STORE: rd=ALUOP; ld_ac=ALUOP; ld_pc=JMP; data_e=STO; wr=STO
- Unlisted outputs are 0 in every phase.
- Halt handling:
  - When phase==4 and opcode==HLT, the halted flag sets on that edge and phase stays at 4.
  - While halted: halt=1, inc_pc=0, and every other strobe is 0.
  - The only exit from halt is rst_n low. An opcode change while halted is ignored.
- SKZ with zero=0: no strobe in phases 5–7; the instruction acts as a NOP.
- zero is sampled only in phase 6; changes in other phases have no effect.
- Opcode is treated as stable from phase 3 on. The controller does not latch it, because the IR owns it.
- Reset asserted mid-cycle (any phase, halted or not): immediate return to phase 0, halted flag cleared, any wr/ld_* deasserted asynchronously.
- Invariants:
  - wr and rd are never both 1.
  - ld_pc and inc_pc are never both 1.
  - wr only in phase 7.

Decomposition:
- Shared package cpu_defs:
  - opcode localparams OP_HLT…OP_JMP
  - phase localparams PH_INST_ADDR…PH_STORE
  - the ALUOP set function
- The IR and ALU reuse the same opcode constants.
- One natural sub-module: cpu_phase_decode, a purely combinational map of (phase, opcode, zero, halted) to the strobe vector.
- The top holds the phase counter and halted flag.

Test Plan:
- Reset/sequence: rst_n=0 for 3 clk, release, opcode=LDA(101) → phase 0..7..0. ld_ir high in phases 2–3; rd high in 1,2,3,5,6,7; ld_ac only in phase 7; inc_pc only in phase 4.
- Store: opcode=STO(110) → data_e=1 in phases 6–7, wr=1 only in phase 7, rd=0 in 5–7, ld_ac never.
- Jump: opcode=JMP(111) → ld_pc=1 in phases 6 and 7, inc_pc only in phase 4, wr/ld_ac/data_e never.
- Skip-if-zero:
  - opcode=SKZ(001), zero=1 at phase 6 → inc_pc=1 in phases 4 and 6.
  - Repeat with zero=0 → inc_pc only in phase 4.
  - zero toggled in phases 5/7 has no effect.
- Halt: opcode=HLT(000) → at phase 4, halt=1 and phase frozen at 4 for ≥20 clk with inc_pc=0. Change opcode to ADD: no change. Pulse rst_n low → phase=0, halt=0 immediately.
- Async reset mid-store: STO, assert rst_n low during phase 7 between edges → wr drops to 0 without waiting for clk, phase=0. An assertion bench checks the rd/wr and ld_pc/inc_pc exclusivity every cycle.
